// File: rtl/blake2_host_driver.sv
// Host-side master for the BLAKE2 hasher: sends the config bytes, streams 64-byte
// blocks from the on-board source, then forwards the digest bytes with a watchdog.
module blake2_host_driver #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  cfg_kk_i,
  input  logic [7:0]  cfg_nn_i,
  input  logic [63:0] cfg_ll_i,
  input  logic        src_valid_i,
  input  logic [7:0]  src_data_i,
  input  logic        src_last_i,
  output logic        src_ready_o,
  output logic [7:0]  data_o,
  output logic [2:0]  data_ctrl_o,
  input  logic        ready_i,
  input  logic        hash_valid_i,
  input  logic [7:0]  hash_i,
  output logic        res_valid_o,
  output logic [7:0]  res_data_o,
  output logic        res_last_o,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {IDLE, CFG, FILL, SEND, WAIT} state_t;

  localparam logic [2:0] CTRL_CFG  = 3'b001;
  localparam logic [2:0] CTRL_BLK  = 3'b011;
  localparam logic [2:0] CTRL_LAST = 3'b101;

  state_t               state, state_n;
  logic [7:0]           kk, kk_n, nn, nn_n;
  logic [63:0]          ll, ll_n;
  logic [6:0]           idx, idx_n, nidx, len, len_n, cnt, cnt_n;
  logic                 last_blk, last_n;
  logic [TIMEOUT_W-1:0] wd, wd_n;
  logic [7:0]           data_n, res_data_n;
  logic [2:0]           ctrl_n;
  logic                 src_ready_n, res_valid_n, res_last_n, busy_n, timeout_n;
  logic                 xfer, buf_we;
  logic [79:0]          cfg_vec;
  logic [7:0]           blk [64];

  assign cfg_vec = {ll, nn, kk};
  assign xfer    = data_ctrl_o[0] & ready_i;
  assign nidx    = idx + 7'd1;
  assign buf_we  = (state == FILL) & src_valid_i & src_ready_o;

  always_ff @(posedge clk) begin
    if (buf_we) blk[idx[5:0]] <= src_data_i;
  end

  // Bytes at or beyond len are sent as zero rather than clearing the buffer on exit.
  always_comb begin
    state_n     = state;
    kk_n        = kk;
    nn_n        = nn;
    ll_n        = ll;
    idx_n       = idx;
    len_n       = len;
    last_n      = last_blk;
    wd_n        = wd;
    cnt_n       = cnt;
    data_n      = data_o;
    ctrl_n      = data_ctrl_o;
    src_ready_n = src_ready_o;
    res_valid_n = 1'b0;
    res_data_n  = res_data_o;
    res_last_n  = 1'b0;
    busy_n      = busy_o;
    timeout_n   = timeout_o;
    case (state)
      IDLE: if (start_i) begin
        kk_n    = cfg_kk_i;
        nn_n    = cfg_nn_i;
        ll_n    = cfg_ll_i;
        idx_n   = '0;
        busy_n  = 1'b1;
        data_n  = cfg_kk_i;
        ctrl_n  = CTRL_CFG;
        state_n = CFG;
      end
      CFG: if (xfer) begin
        if (idx == 7'd9) begin
          idx_n = '0;
          if (kk == '0 && ll == '0) begin
            len_n   = '0;
            last_n  = 1'b1;
            data_n  = '0;
            ctrl_n  = CTRL_LAST;
            state_n = SEND;
          end else begin
            data_n      = '0;
            ctrl_n      = '0;
            src_ready_n = 1'b1;
            state_n     = FILL;
          end
        end else begin
          idx_n  = nidx;
          data_n = cfg_vec[{nidx, 3'b000} +: 8];
        end
      end
      FILL: if (src_valid_i && src_ready_o) begin
        if (idx == 7'd63 || src_last_i) begin
          len_n       = nidx;
          last_n      = src_last_i;
          idx_n       = '0;
          src_ready_n = 1'b0;
          data_n      = (idx == '0) ? src_data_i : blk[0];
          ctrl_n      = src_last_i ? CTRL_LAST : CTRL_BLK;
          state_n     = SEND;
        end else begin
          idx_n = nidx;
        end
      end
      SEND: if (xfer) begin
        if (idx == 7'd63) begin
          idx_n  = '0;
          data_n = '0;
          ctrl_n = '0;
          if (last_blk) begin
            wd_n    = '0;
            cnt_n   = '0;
            state_n = WAIT;
          end else begin
            src_ready_n = 1'b1;
            state_n     = FILL;
          end
        end else begin
          idx_n  = nidx;
          data_n = (nidx < len) ? blk[nidx[5:0]] : '0;
        end
      end
      WAIT: begin
        if (hash_valid_i) begin
          wd_n        = '0;
          res_valid_n = 1'b1;
          res_data_n  = hash_i;
          cnt_n       = cnt + 7'd1;
          if ({1'b0, cnt} + 8'd1 == nn) begin
            res_last_n = 1'b1;
            busy_n     = 1'b0;
            state_n    = IDLE;
          end
        end else begin
          wd_n = wd + 1'b1;
          if (wd_n == '1) begin
            timeout_n = 1'b1;
            busy_n    = 1'b0;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      kk          <= '0;
      nn          <= '0;
      ll          <= '0;
      idx         <= '0;
      len         <= '0;
      last_blk    <= 1'b0;
      wd          <= '0;
      cnt         <= '0;
      data_o      <= '0;
      data_ctrl_o <= '0;
      src_ready_o <= 1'b0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_last_o  <= 1'b0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_n;
      kk          <= kk_n;
      nn          <= nn_n;
      ll          <= ll_n;
      idx         <= idx_n;
      len         <= len_n;
      last_blk    <= last_n;
      wd          <= wd_n;
      cnt         <= cnt_n;
      data_o      <= data_n;
      data_ctrl_o <= ctrl_n;
      src_ready_o <= src_ready_n;
      res_valid_o <= res_valid_n;
      res_data_o  <= res_data_n;
      res_last_o  <= res_last_n;
      busy_o      <= busy_n;
      timeout_o   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_blake2_host_driver.sv
// Scoreboard bench for blake2_host_driver: stimulus pushes expected hasher-side bytes
// and result bytes into queues; a negedge monitor pops and compares them.
module tb_blake2_host_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  cfg_kk_i = '0, cfg_nn_i = '0;
  logic [63:0] cfg_ll_i = '0;
  logic        src_valid_i = 1'b0, src_last_i = 1'b0;
  logic [7:0]  src_data_i = '0;
  logic        src_ready_o;
  logic [7:0]  data_o;
  logic [2:0]  data_ctrl_o;
  logic        ready_i = 1'b1;
  logic        hash_valid_i = 1'b0;
  logic [7:0]  hash_i = '0;
  logic        res_valid_o, res_last_o, busy_o, timeout_o;
  logic [7:0]  res_data_o;

  blake2_host_driver #(.TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .cfg_kk_i(cfg_kk_i), .cfg_nn_i(cfg_nn_i), .cfg_ll_i(cfg_ll_i),
    .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_last_i(src_last_i),
    .src_ready_o(src_ready_o), .data_o(data_o), .data_ctrl_o(data_ctrl_o),
    .ready_i(ready_i), .hash_valid_i(hash_valid_i), .hash_i(hash_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_last_o(res_last_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  logic [10:0] exp_x[$];
  logic [8:0]  exp_r[$];
  logic [7:0]  msg[$];
  logic        tog = 1'b0, src_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  always begin
    @(posedge clk);
    #1 ready_i = tog ? ~ready_i : 1'b1;
  end

  // Monitor: hasher-side transfers, stall stability, result bytes and their latency.
  initial begin : monitor
    logic        stall_pend, prev_hv;
    logic [10:0] stall_val;
    stall_pend = 1'b0;
    prev_hv    = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pend = 1'b0;
        prev_hv    = 1'b0;
      end else begin
        if (data_ctrl_o[0] && ready_i) begin
          if (exp_x.size() == 0) begin
            checks++; errors++;
            $display("FAIL xfer_unexpected: got %0h expected none", {data_ctrl_o, data_o});
          end else chk("xfer", {data_ctrl_o, data_o}, exp_x.pop_front());
          if (data_ctrl_o[2:1] != 2'b00) chk("src_ready_in_send", src_ready_o, 0);
        end
        if (stall_pend && data_ctrl_o[0]) chk("stall_stable", {data_ctrl_o, data_o}, stall_val);
        stall_pend = data_ctrl_o[0] && !ready_i;
        stall_val  = {data_ctrl_o, data_o};
        if (res_valid_o) begin
          if (exp_r.size() == 0) begin
            checks++; errors++;
            $display("FAIL result_unexpected: got %0h expected none", {res_last_o, res_data_o});
          end else chk("result", {res_last_o, res_data_o}, exp_r.pop_front());
          chk("result_latency", prev_hv, 1);
        end
        prev_hv = hash_valid_i;
        if (src_ready_o) src_seen = 1'b1;
      end
    end
  end

  function automatic void push_job(input logic [7:0] kk, input logic [7:0] nn,
                                   input logic [63:0] ll);
    int unsigned n, nblk;
    exp_x.push_back({3'b001, kk});
    exp_x.push_back({3'b001, nn});
    for (int unsigned i = 0; i < 8; i++) exp_x.push_back({3'b001, ll[8*i +: 8]});
    n    = msg.size();
    nblk = (n == 0) ? 1 : (n + 63) / 64;
    for (int unsigned b = 0; b < nblk; b++)
      for (int unsigned j = 0; j < 64; j++)
        exp_x.push_back({(b == nblk - 1) ? 3'b101 : 3'b011,
                         (b * 64 + j < n) ? msg[b * 64 + j] : 8'h00});
  endfunction

  task automatic do_start(input logic [7:0] kk, input logic [7:0] nn, input logic [63:0] ll);
    push_job(kk, nn, ll);
    src_seen = 1'b0;
    cfg_kk_i = kk; cfg_nn_i = nn; cfg_ll_i = ll;
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  task automatic feed();
    int unsigned c;
    for (int unsigned i = 0; i < msg.size(); i++) begin
      src_valid_i = 1'b1;
      src_data_i  = msg[i];
      src_last_i  = (i == msg.size() - 1);
      c = 0;
      @(negedge clk);
      while (!src_ready_o && c < 2000) begin @(negedge clk); c++; end
      if (!src_ready_o) begin bound_fail("feed"); break; end
      @(posedge clk); #1;
    end
    src_valid_i = 1'b0;
    src_last_i  = 1'b0;
  endtask

  task automatic wait_last_block();
    int unsigned k, c;
    k = 0; c = 0;
    while (k < 64 && c < 5000) begin
      @(negedge clk); c++;
      if (data_ctrl_o[0] && ready_i && data_ctrl_o[2:1] == 2'b10) k++;
    end
    if (k < 64) bound_fail("wait_last_block");
    @(posedge clk); #1;
  endtask

  task automatic send_hash(input int unsigned nn, input logic [7:0] base);
    for (int unsigned i = 0; i < nn; i++) begin
      hash_valid_i = 1'b1;
      hash_i       = base + 8'(i);
      exp_r.push_back({(i == nn - 1), base + 8'(i)});
      @(posedge clk); #1;
    end
    hash_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_job", busy_o, 0);
    chk("results_drained", exp_r.size(), 0);
    chk("xfers_drained", exp_x.size(), 0);
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
  endtask

  task automatic out_zero(input string name);
    chk(name, {src_ready_o, data_o, data_ctrl_o, res_valid_o, res_data_o, res_last_o,
               busy_o, timeout_o}, 0);
  endtask

  initial begin : stim
    int unsigned c;
    #3 out_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Job 1: "abc", stray hash_valid during CFG must be ignored.
    set_abc();
    do_start(8'd0, 8'd32, 64'd3);
    chk("busy_after_start", busy_o, 1);
    hash_valid_i = 1'b1; hash_i = 8'hEE;
    repeat (2) @(posedge clk);
    #1 hash_valid_i = 1'b0;
    feed();
    wait_last_block();
    send_hash(32, 8'h40);

    // Job 2: two full blocks; a second start while busy must be ignored.
    msg.delete();
    for (int unsigned i = 0; i < 128; i++) msg.push_back(8'(i * 7 + 1));
    do_start(8'd0, 8'd4, 64'd128);
    cfg_kk_i = 8'h55; cfg_nn_i = 8'h11; cfg_ll_i = 64'h1234;
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    feed();
    wait_last_block();
    send_hash(4, 8'h90);

    // Job 3: empty message, no source traffic at all.
    msg.delete();
    do_start(8'd0, 8'd8, 64'd0);
    wait_last_block();
    send_hash(8, 8'hC0);
    chk("src_ready_never", src_seen, 0);

    // Job 4: keyed, ready toggling every cycle, maximum digest length.
    msg.delete();
    for (int unsigned i = 0; i < 69; i++) msg.push_back(8'(8'hF0 ^ i));
    tog = 1'b1;
    do_start(8'd32, 8'd64, 64'd5);
    feed();
    wait_last_block();
    tog = 1'b0;
    send_hash(64, 8'h00);

    // Job 5: no hash output -> watchdog.
    msg.delete();
    do_start(8'd0, 8'd16, 64'd0);
    wait_last_block();
    repeat (14) @(posedge clk);
    #1 chk("timeout_before", {timeout_o, busy_o}, 2'b01);
    @(posedge clk);
    #1 chk("timeout_fired", {timeout_o, busy_o}, 2'b10);
    exp_r.delete();

    // Job 6: new start accepted after timeout; timeout stays sticky.
    set_abc();
    do_start(8'd0, 8'd1, 64'd3);
    chk("busy_after_timeout_start", busy_o, 1);
    feed();
    wait_last_block();
    send_hash(1, 8'h77);
    chk("timeout_sticky", timeout_o, 1);

    // Job 7: asynchronous reset in the middle of SEND.
    set_abc();
    do_start(8'd0, 8'd32, 64'd3);
    feed();
    c = 0;
    while (!(data_ctrl_o[0] && data_ctrl_o[2:1] == 2'b10 && data_o == 8'h63) && c < 2000) begin
      @(negedge clk); c++;
    end
    if (c >= 2000) bound_fail("reach_send");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 out_zero("reset_mid_send");
    exp_x.delete();
    exp_r.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Job 8: full job after the abort.
    set_abc();
    do_start(8'd0, 8'd32, 64'd3);
    feed();
    wait_last_block();
    send_hash(32, 8'h20);
    chk("timeout_cleared_by_reset", timeout_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
